// File: rtl/jk_universal_reg_if.sv
// Control/data bundle for jk_universal_reg.
// The master drives the operation; the slave returns register state.
interface jk_universal_reg_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic             si;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             wrap;

    modport master (
        output en, mode, j, k, d, si,
        input  q, so, wrap
    );

    modport slave (
        input  en, mode, j, k, d, si,
        output q, so, wrap
    );
endinterface

// File: rtl/jk_universal_reg.sv
// Multi-mode WIDTH-bit register: per-bit JK, load, toggle,
// modulo up/down count with wrap pulse, and serial shift.
module jk_universal_reg #(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MOD       = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    jk_universal_reg_if.slave bus
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_JK   = 3'b001,
        M_LOAD = 3'b010,
        M_TGL  = 3'b011,
        M_UP   = 3'b100,
        M_DOWN = 3'b101,
        M_SHL  = 3'b110,
        M_SHR  = 3'b111
    } mode_e;

    // One extra bit so MOD = 2**WIDTH does not overflow the compare.
    localparam logic [WIDTH:0]   MAXV  = (WIDTH+1)'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    mode_e            mode;
    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_nxt;
    logic             w_nxt;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH:0]   q_ext;

    assign mode  = mode_e'(bus.mode);
    assign q_ext = {1'b0, q_r};

    // A 1-bit register shifts the serial input straight in.
    if (WIDTH == 1) begin : g_w1
        assign shl_v = bus.si;
        assign shr_v = bus.si;
    end else begin : g_wn
        assign shl_v = {q_r[WIDTH-2:0], bus.si};
        assign shr_v = {bus.si, q_r[WIDTH-1:1]};
    end

    always_comb begin
        q_nxt = q_r;
        w_nxt = 1'b0;
        if (bus.en) begin
            unique case (mode)
                M_HOLD: q_nxt = q_r;
                M_JK:   q_nxt = (bus.j & ~q_r) | (~bus.k & q_r);
                M_LOAD: q_nxt = bus.d;
                M_TGL:  q_nxt = q_r ^ bus.d;
                M_UP: begin
                    if (q_ext >= MAXV) begin
                        q_nxt = '0;
                        w_nxt = 1'b1;
                    end else begin
                        q_nxt = q_r + 1'b1;
                    end
                end
                M_DOWN: begin
                    if (q_r == '0) begin
                        q_nxt = MAXV[WIDTH-1:0];
                        w_nxt = 1'b1;
                    end else begin
                        q_nxt = q_r - 1'b1;
                    end
                end
                M_SHL:  q_nxt = shl_v;
                M_SHR:  q_nxt = shr_v;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r    <= RST_Q;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= w_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.so   = (mode == M_SHL) ? q_r[WIDTH-1] : q_r[0];
endmodule

// File: tb/tb_jk_universal_reg.sv
// Scoreboard bench for jk_universal_reg: WIDTH=4, MOD=10,
// plus a RESET_VAL=5 instance fed the same inputs.
module tb_jk_universal_reg;
    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] JK   = 3'b001;
    localparam logic [2:0] LOAD = 3'b010;
    localparam logic [2:0] TGL  = 3'b011;
    localparam logic [2:0] UP   = 3'b100;
    localparam logic [2:0] DOWN = 3'b101;
    localparam logic [2:0] SHL  = 3'b110;
    localparam logic [2:0] SHR  = 3'b111;

    typedef struct {
        int         dut;
        logic [3:0] q;
        logic       w;
        logic       so;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    jk_universal_reg_if #(.WIDTH(4)) ifa ();
    jk_universal_reg_if #(.WIDTH(4)) ifb ();

    assign ifb.en   = ifa.en;
    assign ifb.mode = ifa.mode;
    assign ifb.j    = ifa.j;
    assign ifb.k    = ifa.k;
    assign ifb.d    = ifa.d;
    assign ifb.si   = ifa.si;

    jk_universal_reg #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    jk_universal_reg #(.WIDTH(4), .MOD(10), .RESET_VAL(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic op(input logic r, input logic e, input logic [2:0] m,
                      input logic [3:0] jj, input logic [3:0] kk,
                      input logic [3:0] dd, input logic s);
        @(negedge clk);
        rst_n    = r;
        ifa.en   = e;
        ifa.mode = m;
        ifa.j    = jj;
        ifa.k    = kk;
        ifa.d    = dd;
        ifa.si   = s;
        @(posedge clk);
    endtask

    task automatic expect_a(input logic [3:0] q, input logic w,
                            input logic so, input string name);
        exp_t e;
        e.dut = 0; e.q = q; e.w = w; e.so = so; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_b(input logic [3:0] q, input logic w,
                            input logic so, input string name);
        exp_t e;
        e.dut = 1; e.q = q; e.w = w; e.so = so; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: checks everything queued for the edge just taken.
    initial begin
        exp_t       e;
        logic [3:0] aq;
        logic       aw;
        logic       aso;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    aq = ifa.q; aw = ifa.wrap; aso = ifa.so;
                end else begin
                    aq = ifb.q; aw = ifb.wrap; aso = ifb.so;
                end
                n_tests++;
                if (aq !== e.q || aw !== e.w || aso !== e.so) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h wrap=%b so=%b, want q=%h wrap=%b so=%b",
                             e.name, aq, aw, aso, e.q, e.w, e.so);
                end
            end
        end
    end

    initial begin
        ifa.en = 1'b0; ifa.mode = HOLD; ifa.j = '0;
        ifa.k = '0; ifa.d = '0; ifa.si = 1'b0;

        op(0, 1, UP, 0, 0, 0, 0);
        expect_a(4'h0, 0, 0, "reset1");
        op(0, 1, UP, 0, 0, 0, 0);
        expect_a(4'h0, 0, 0, "reset2");
        expect_b(4'h5, 0, 1, "reset2_rv5");

        op(1, 1, UP, 0, 0, 0, 0);
        expect_a(4'h1, 0, 1, "release_up");
        for (int i = 2; i <= 10; i++) begin
            op(1, 1, UP, 0, 0, 0, 0);
            expect_a(4'(i % 10), (i == 10), 1'((i % 10) & 1), "up_count");
        end
        op(1, 1, HOLD, 0, 0, 0, 0);
        expect_a(4'h0, 0, 0, "hold_wrap_clears");

        op(1, 1, DOWN, 0, 0, 0, 0);
        expect_a(4'h9, 1, 1, "down_wrap");
        op(1, 1, LOAD, 0, 0, 4'hC, 0);
        expect_a(4'hC, 0, 0, "load_oor");
        op(1, 1, UP, 0, 0, 0, 0);
        expect_a(4'h0, 1, 0, "up_from_oor");
        op(1, 0, UP, 0, 0, 0, 0);
        expect_a(4'h0, 0, 0, "en0_clears_wrap");
        op(1, 1, LOAD, 0, 0, 4'hC, 0);
        expect_a(4'hC, 0, 0, "load_oor2");
        op(1, 1, DOWN, 0, 0, 0, 0);
        expect_a(4'hB, 0, 1, "down_from_oor");

        op(1, 1, LOAD, 0, 0, 4'b0101, 0);
        expect_a(4'b0101, 0, 1, "load_jk");
        op(1, 1, JK, 4'b1100, 4'b1010, 0, 0);
        expect_a(4'b1101, 0, 1, "jk_perbit");
        op(1, 1, LOAD, 0, 0, 4'b0101, 0);
        expect_a(4'b0101, 0, 1, "load_jk2");
        op(1, 0, JK, 4'b1100, 4'b1010, 0, 0);
        expect_a(4'b0101, 0, 1, "jk_en0");

        op(1, 1, LOAD, 0, 0, 4'b1011, 0);
        expect_a(4'b1011, 0, 1, "load_shift");
        op(1, 0, SHL, 0, 0, 0, 0);
        expect_a(4'b1011, 0, 1, "so_shl_before");
        op(1, 1, SHL, 0, 0, 0, 0);
        expect_a(4'b0110, 0, 0, "shl_si0");
        op(1, 1, SHR, 0, 0, 0, 1);
        expect_a(4'b1011, 0, 1, "shr_si1");

        op(1, 1, LOAD, 0, 0, 4'h0, 0);
        expect_a(4'h0, 0, 0, "load0");
        for (int i = 1; i <= 7; i++) begin
            op(1, 1, UP, 0, 0, 0, 0);
            expect_a(4'(i), 0, 1'(i & 1), "count_to7");
        end
        op(0, 1, UP, 0, 0, 0, 0);
        expect_a(4'h0, 0, 0, "reset_mid7");
        expect_b(4'h5, 0, 1, "reset_mid7_rv5");
        op(1, 1, LOAD, 0, 0, 4'h9, 0);
        expect_a(4'h9, 0, 1, "load9");
        op(0, 1, UP, 0, 0, 0, 0);
        expect_a(4'h0, 0, 0, "reset_at9_nowrap");
        expect_b(4'h5, 0, 1, "reset_at9_rv5");

        op(1, 1, TGL, 0, 0, 4'b1111, 0);
        expect_a(4'b1111, 0, 1, "toggle_on0");
        expect_b(4'b1010, 0, 0, "toggle_on5");

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
